// File: rtl/pipeline_stall_controller.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, data-memory wait FSM with watchdog.
// Optional stall performance counter enabled by defining STALL_CNT_EN; otherwise stall_cycles reads as zero.
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_rn,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        id_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_write_en,
  output logic        ifid_write_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        mem_hold,
  output logic        mem_err,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur, nxt;
  logic [7:0] timer, timer_nxt;
  logic       err_r;
  logic       lu, ms;

  assign lu = ex_m2reg && ex_wreg && (ex_rn != 5'd0) &&
              ((id_use_rs && (id_rs == ex_rn)) || (id_use_rt && (id_rt == ex_rn)));

  assign ms = ((cur == RUN) && dmem_req && !dmem_ack) ||
              ((cur == MEM_WAIT) && !dmem_ack);

  always_ff @(posedge clk) begin
    if (clr) begin
      cur   <= RUN;
      timer <= '0;
      err_r <= 1'b0;
    end else begin
      cur   <= nxt;
      timer <= timer_nxt;
      if (nxt == ERR) err_r <= 1'b1;
    end
  end

  always_comb begin
    nxt       = cur;
    timer_nxt = timer;
    case (cur)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          nxt       = MEM_WAIT;
          timer_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack || !dmem_req) begin
          nxt       = RUN;
          timer_nxt = '0;
        end else if (timer == TMO_LAST) begin
          nxt = ERR;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      ERR:     nxt = ERR;
      default: begin
        nxt       = RUN;
        timer_nxt = '0;
      end
    endcase
  end

  // Priority chain: clr, ERR, memory stall, load-use, branch; a branch under load-use waits a cycle.
  always_comb begin
    pc_write_en   = 1'b0;
    ifid_write_en = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    mem_hold      = 1'b0;
    if (clr) begin
      mem_hold = 1'b0;
    end else if (cur == ERR) begin
      mem_hold = 1'b1;
    end else if (ms) begin
      mem_hold = 1'b1;
    end else if (lu) begin
      idex_bubble = 1'b1;
    end else if (id_branch_taken) begin
      ifid_flush    = 1'b1;
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
    end else begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
    end
  end

  assign state   = cur;
  assign mem_err = err_r;

`ifdef STALL_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if ((cur != ERR) && !pc_write_en && (cnt != '1)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign stall_cycles = cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a behavioural model queues expected outputs per driven cycle.
module tb_pipeline_stall_controller;

  localparam int unsigned MT = 4;

  logic        clk;
  logic        clr;
  logic [4:0]  id_rs, id_rt, ex_rn;
  logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg, id_branch_taken;
  logic        dmem_req, dmem_ack;
  logic        pc_write_en, ifid_write_en, ifid_flush, idex_bubble, mem_hold, mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cycles;

  pipeline_stall_controller #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .clr(clr),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .id_branch_taken(id_branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .mem_hold(mem_hold), .mem_err(mem_err),
    .state(state), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic pcw, ifw, fl, bub, hold, err;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [1:0]  m_st;
  logic [7:0]  m_tmr;
  logic        m_err;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pc_write_en",   {31'd0, pc_write_en},   {31'd0, e.pcw});
      check("ifid_write_en", {31'd0, ifid_write_en}, {31'd0, e.ifw});
      check("ifid_flush",    {31'd0, ifid_flush},    {31'd0, e.fl});
      check("idex_bubble",   {31'd0, idex_bubble},   {31'd0, e.bub});
      check("mem_hold",      {31'd0, mem_hold},      {31'd0, e.hold});
      check("mem_err",       {31'd0, mem_err},       {31'd0, e.err});
      check("state",         {30'd0, state},         {30'd0, e.st});
      check("stall_cycles",  stall_cycles,           e.cnt);
    end
  end

  task automatic drive(input logic c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rn,
                       input logic wr, input logic m2, input logic br,
                       input logic req, input logic ack);
    exp_t e;
    logic lu, ms;
    clr = c; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_rn = rn; ex_wreg = wr; ex_m2reg = m2; id_branch_taken = br;
    dmem_req = req; dmem_ack = ack;

    lu = m2 && wr && (rn != 0) && ((urs && rs == rn) || (urt && rt == rn));
    ms = (m_st == 2'b00 && req && !ack) || (m_st == 2'b01 && !ack);
    e.pcw = 0; e.ifw = 0; e.fl = 0; e.bub = 0; e.hold = 0;
    e.err = m_err; e.st = m_st; e.cnt = m_cnt;
    if (c) begin
      e.hold = 0;
    end else if (m_st == 2'b10) begin
      e.hold = 1;
    end else if (ms) begin
      e.hold = 1;
    end else if (lu) begin
      e.bub = 1;
    end else begin
      e.pcw = 1; e.ifw = 1; e.fl = br;
    end
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (c) begin
      m_st = 2'b00; m_tmr = 0; m_err = 0; m_cnt = 0;
    end else begin
`ifdef STALL_CNT_EN
      if (m_st != 2'b10 && !e.pcw && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      if (m_st == 2'b00) begin
        if (req && !ack) begin m_st = 2'b01; m_tmr = 1; end
      end else if (m_st == 2'b01) begin
        if (ack || !req) begin
          m_st = 2'b00; m_tmr = 0;
        end else if (m_tmr == 8'(MT - 1)) begin
          m_st = 2'b10; m_err = 1;
        end else begin
          m_tmr = m_tmr + 1;
        end
      end
    end
  endtask

  task automatic idle(input logic c);
    drive(c, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem(input logic c, input logic req, input logic ack);
    drive(c, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, req, ack);
  endtask

  initial begin
    clr = 1; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; ex_rn = 0;
    ex_wreg = 0; ex_m2reg = 0; id_branch_taken = 0; dmem_req = 0; dmem_ack = 0;
    @(posedge clk);
    #1;
    m_st = 0; m_tmr = 0; m_err = 0; m_cnt = 0;

    // Reset state and quiet pipeline
    idle(1'b1);
    idle(1'b0);

    // Load-use on rs, then bubble in EX
    drive(0, 5'd5, 5'd7, 1, 1, 5'd5, 1, 1, 0, 0, 0);
    idle(1'b0);
    // Load-use on rt
    drive(0, 5'd1, 5'd9, 1, 1, 5'd9, 1, 1, 0, 0, 0);
    // Zero register, unused rt operand, non-load writer
    drive(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0);
    drive(0, 5'd3, 5'd6, 1, 0, 5'd6, 1, 1, 0, 0, 0);
    drive(0, 5'd6, 5'd6, 1, 1, 5'd6, 1, 0, 0, 0, 0);

    // Branch versus load-use
    drive(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 0);
    drive(0, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 1, 0, 0);

    // Memory wait: ack on the third cycle
    idle(1'b1);
    mem(0, 1, 0);
    check("mw_enter_state", {30'd0, state}, 32'd1);
    mem(0, 1, 0);
    mem(0, 1, 1);
    check("mw_exit_state", {30'd0, state}, 32'd0);
`ifdef STALL_CNT_EN
    check("mw_stall_cycles", stall_cycles, 32'd2);
`else
    check("mw_stall_cycles", stall_cycles, 32'd0);
`endif
    // Same-cycle ack: no stall
    mem(0, 1, 1);
    mem(0, 0, 0);

    // Watchdog
    idle(1'b1);
    for (int i = 0; i < 4; i++) mem(0, 1, 0);
    check("wd_state", {30'd0, state}, 32'd2);
    check("wd_err", {31'd0, mem_err}, 32'd1);
    mem(0, 1, 0);
    mem(0, 0, 1);
    check("wd_hold_state", {30'd0, state}, 32'd2);
    idle(1'b1);
    check("wd_clr_state", {30'd0, state}, 32'd0);
    check("wd_clr_err", {31'd0, mem_err}, 32'd0);

    // Reset mid-wait, then a full timeout proves the timer restarted
    mem(0, 1, 0);
    mem(0, 1, 0);
    mem(1, 1, 0);
    check("mid_clr_cnt", stall_cycles, 32'd0);
    for (int i = 0; i < 4; i++) mem(0, 1, 0);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 24) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 2) == 0));
    end

    idle(1'b0);
    repeat (2) @(negedge clk);
    if (sb.size() != 0) check("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
